csr_trap_sequencer: RTL and testbench
=====================================

Name: csr_trap_sequencer

Overview:
- Controller that owns the single read/write port of the 4-entry machine CSR register file (mcause, mstatus, mepc, mtvec).
- Sequences multi-cycle trap entry (ecall/exception) and mret return as fixed write/read series.
- Arbitrates the port with the EXU system-instruction path (csrrw/csrrs); emits a PC redirect to fetch.
- Performs the reset-time mstatus initialisation.

Parameters:
- ADDR_WIDTH, 2, CSR file index width (0 mcause, 1 mstatus, 2 mepc, 3 mtvec)
- DATA_WIDTH, 64, CSR/PC data width
- MSTATUS_RST, 64'ha00001800, value written to mstatus after reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- trap_req  in  1  trap-entry request; held until sys_ack
- trap_cause  in  DATA_WIDTH  mcause value (ecall = 64'hb)
- trap_pc  in  DATA_WIDTH  faulting PC, written to mepc
- mret_req  in  1  mret request; held until sys_ack
- sys_ack  out  1  one-cycle pulse: trap_req/mret_req accepted
- busy  out  1  sequencer not in IDLE
- redirect_vld  out  1  one-cycle pulse: redirect_pc valid
- redirect_pc  out  DATA_WIDTH  new fetch PC
- inst_req  in  1  EXU CSR-instruction access request
- inst_gnt  out  1  port granted this cycle
- inst_raddr  in  ADDR_WIDTH  instruction read index
- inst_rdata  out  DATA_WIDTH  read data (csrf_rdata passthrough)
- inst_wen  in  1  instruction write enable
- inst_waddr  in  ADDR_WIDTH  instruction write index
- inst_wdata  in  DATA_WIDTH  instruction write data
- csrf_raddr  out  ADDR_WIDTH  CSR file read index
- csrf_rdata  in  DATA_WIDTH  CSR file read data, combinational in csrf_raddr
- csrf_waddr  out  ADDR_WIDTH  CSR file write index
- csrf_wdata  out  DATA_WIDTH  CSR file write data
- csrf_wen  out  1  CSR file write enable, takes effect at next clk edge

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values:
  - state = INIT
  - sys_ack = 0, redirect_vld = 0, redirect_pc = 0
  - latched pc/cause = 0
  - busy = 1 (combinational, state != IDLE)
- Reset mid-sequence aborts immediately: no further writes, no redirect.
- States and transitions:
  - INIT: csrf_wen=1, waddr=mstatus, wdata=MSTATUS_RST; -> IDLE.
  - IDLE:
    - trap_req: latch trap_pc/trap_cause, sys_ack=1 -> T_EPC.
    - else mret_req: sys_ack=1 -> M_STAT.
    - else port is muxed to inst_*.
  - T_EPC: write mepc = latched pc -> T_CAUSE.
  - T_CAUSE: write mcause = latched cause -> T_STAT.
  - T_STAT: read mstatus; same-cycle write back with MPIE(7)=MIE(3), MIE=0, MPP(12:11)=2'b11; -> T_VEC.
  - T_VEC: read mtvec; register redirect_pc = {mtvec[63:2],2'b00}, redirect_vld=1 next cycle; -> IDLE.
  - M_STAT: read mstatus; write MIE=MPIE, MPIE=1, MPP=2'b11 -> M_EPC.
  - M_EPC: read mepc; register redirect_pc = mepc, redirect_vld=1 next cycle; -> IDLE.
- Latency:
  - Trap: redirect_vld 5 cycles after the sys_ack cycle.
  - mret: redirect_vld 3 cycles after the sys_ack cycle.
- redirect_vld cycle coincides with IDLE; a new request is accepted in that cycle.
- Arbitration:
  - inst_gnt = inst_req & IDLE & ~trap_req & ~mret_req (combinational).
  - Priority: trap_req > mret_req > inst_req.
  - An ungranted inst_req must be held; its write is suppressed (csrf_wen=0).
- Outside IDLE, inst_* are ignored and inst_rdata shows the sequencer read. inst_rdata is valid only when inst_gnt=1.
- csrf_wen=0 in IDLE unless inst_gnt & inst_wen.
- Requests arriving in INIT or in any busy state: no ack; they are taken once IDLE is reached.

Optional Feature:
- Macro: CSR_TRAP_VECTORED_EN.
- Defined:
  - In T_VEC, if mtvec[1:0]==2'b01 and latched cause[63]==1: redirect_pc = {mtvec[63:2],2'b00} + (cause[5:0]<<2).
  - Otherwise direct mode.
- Undefined: always direct mode; mtvec[1:0] ignored.

Decomposition:
- Shared package csr_pkg:
  - CSR index localparams IDX_MCAUSE=0, IDX_MSTATUS=1, IDX_MEPC=2, IDX_MTVEC=3
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11)
  - MSTATUS_RST default
  - ECALL_CAUSE=64'hb
  - state enum type
- One sub-module: csr_trap_target (combinational redirect-PC calculation incl. vectored option); FSM, mux and arbitration stay in the top.

Test Plan:
- Reset release: rst high 2 cycles -> first cycle after release csrf_wen=1, waddr=1, wdata=64'ha00001800; busy=1; IDLE next cycle.
- Trap entry: mtvec=64'h8000_0100, mstatus=64'ha00001808, trap_req, trap_pc=64'h8000_0040, cause=64'hb:
  - Writes in order: mepc=64'h8000_0040, mcause=64'hb, mstatus=64'ha00001880.
  - redirect_vld=1 with pc 64'h8000_0100 exactly 5 cycles after sys_ack.
- mret: mstatus=64'ha00001880, mepc=64'h8000_0044 -> mstatus written 64'ha00001888; redirect_pc=64'h8000_0044 3 cycles after sys_ack.
- Contention:
  - trap_req and inst_req(wen=1, waddr=3) in same IDLE cycle -> inst_gnt=0, no mtvec write.
  - inst held -> granted in the redirect cycle.
  - trap_req and mret_req together -> trap sequence.
- Reset during T_CAUSE -> no mstatus write, no redirect_vld, INIT write follows release.
- CSR_TRAP_VECTORED_EN defined, mtvec=64'h8000_0101, cause=64'h8000_0000_0000_0007 -> redirect_pc=64'h8000_011c; undefined -> 64'h8000_0100.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared CSR indices, mstatus bit positions and sequencer state type
package csr_pkg;
  localparam logic [1:0] IDX_MCAUSE = 2'd0;
  localparam logic [1:0] IDX_MSTATUS = 2'd1;
  localparam logic [1:0] IDX_MEPC = 2'd2;
  localparam logic [1:0] IDX_MTVEC = 2'd3;
  localparam int MIE = 3;
  localparam int MPIE = 7;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;
  localparam logic [63:0] MSTATUS_RST_DEFAULT = 64'ha00001800;
  localparam logic [63:0] ECALL_CAUSE = 64'hb;
  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_T_EPC, S_T_CAUSE, S_T_STAT, S_T_VEC, S_M_STAT, S_M_EPC
  } state_t;
endpackage

// File: rtl/csr_trap_target.sv
// csr_trap_target: trap redirect PC from mtvec; vectored mode under CSR_TRAP_VECTORED_EN
module csr_trap_target #(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic [DATA_WIDTH-1:0] cause,
  output logic [DATA_WIDTH-1:0] pc
);
`ifdef CSR_TRAP_VECTORED_EN
  assign pc = {mtvec[DATA_WIDTH-1:2], 2'b00} +
              ((mtvec[1:0] == 2'b01 && cause[DATA_WIDTH-1]) ? DATA_WIDTH'({cause[5:0], 2'b00}) : '0);
`else
  logic unused_bits;
  assign unused_bits = ^{cause, mtvec[1:0]};
  assign pc = {mtvec[DATA_WIDTH-1:2], 2'b00};
`endif
endmodule

// File: rtl/csr_trap_sequencer.sv
// csr_trap_sequencer: owns the CSR file port, sequences trap entry/mret, arbitrates EXU access (CSR_TRAP_VECTORED_EN selects vectored traps)
module csr_trap_sequencer import csr_pkg::*; #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 64,
  parameter logic [DATA_WIDTH-1:0] MSTATUS_RST = MSTATUS_RST_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trap_req,
  input  logic [DATA_WIDTH-1:0] trap_cause,
  input  logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  mret_req,
  output logic                  sys_ack,
  output logic                  busy,
  output logic                  redirect_vld,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  inst_req,
  output logic                  inst_gnt,
  input  logic [ADDR_WIDTH-1:0] inst_raddr,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic                  inst_wen,
  input  logic [ADDR_WIDTH-1:0] inst_waddr,
  input  logic [DATA_WIDTH-1:0] inst_wdata,
  output logic [ADDR_WIDTH-1:0] csrf_raddr,
  input  logic [DATA_WIDTH-1:0] csrf_rdata,
  output logic [ADDR_WIDTH-1:0] csrf_waddr,
  output logic [DATA_WIDTH-1:0] csrf_wdata,
  output logic                  csrf_wen
);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] pc_q, cause_q, trap_st, mret_st, target;
  logic idle;
  assign idle = state == S_IDLE;
  assign busy = !idle;
  // rst gates every port action so an in-flight sequence stops writing at once
  assign sys_ack = idle & ~rst & (trap_req | mret_req);
  assign inst_gnt = idle & ~rst & inst_req & ~trap_req & ~mret_req;
  assign inst_rdata = csrf_rdata;
  always_comb begin
    trap_st = csrf_rdata;
    trap_st[MPIE] = csrf_rdata[MIE];
    trap_st[MIE] = 1'b0;
    trap_st[MPP_HI:MPP_LO] = 2'b11;
    mret_st = csrf_rdata;
    mret_st[MIE] = csrf_rdata[MPIE];
    mret_st[MPIE] = 1'b1;
    mret_st[MPP_HI:MPP_LO] = 2'b11;
  end
  assign csrf_raddr = (state == S_T_STAT || state == S_M_STAT) ? ADDR_WIDTH'(IDX_MSTATUS) :
                      state == S_T_VEC ? ADDR_WIDTH'(IDX_MTVEC) :
                      state == S_M_EPC ? ADDR_WIDTH'(IDX_MEPC) : inst_raddr;
  assign csrf_wen = ~rst & ((state inside {S_INIT, S_T_EPC, S_T_CAUSE, S_T_STAT, S_M_STAT}) |
                            (inst_gnt & inst_wen));
  assign csrf_waddr = state == S_T_EPC ? ADDR_WIDTH'(IDX_MEPC) :
                      state == S_T_CAUSE ? ADDR_WIDTH'(IDX_MCAUSE) :
                      idle ? inst_waddr : ADDR_WIDTH'(IDX_MSTATUS);
  assign csrf_wdata = state == S_INIT ? MSTATUS_RST :
                      state == S_T_EPC ? pc_q :
                      state == S_T_CAUSE ? cause_q :
                      state == S_T_STAT ? trap_st :
                      state == S_M_STAT ? mret_st : inst_wdata;
  csr_trap_target #(.DATA_WIDTH(DATA_WIDTH)) u_target (
    .mtvec(csrf_rdata),
    .cause(cause_q),
    .pc   (target)
  );
  always_comb begin
    state_n = state;
    case (state)
      S_INIT:    state_n = S_IDLE;
      S_IDLE:    state_n = trap_req ? S_T_EPC : mret_req ? S_M_STAT : S_IDLE;
      S_T_EPC:   state_n = S_T_CAUSE;
      S_T_CAUSE: state_n = S_T_STAT;
      S_T_STAT:  state_n = S_T_VEC;
      S_M_STAT:  state_n = S_M_EPC;
      default:   state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      redirect_vld <= 1'b0;
      redirect_pc <= '0;
      pc_q <= '0;
      cause_q <= '0;
    end else begin
      state <= state_n;
      redirect_vld <= state == S_T_VEC || state == S_M_EPC;
      if (idle && trap_req) begin
        pc_q <= trap_pc;
        cause_q <= trap_cause;
      end
      if (state == S_T_VEC) redirect_pc <= target;
      else if (state == S_M_EPC) redirect_pc <= csrf_rdata;
    end
  end
endmodule

// File: tb/tb_csr_trap_sequencer.sv
// tb_csr_trap_sequencer: table-driven EXU access plus trap/mret sequences checked against a CSR write scoreboard
module tb_csr_trap_sequencer;
  logic clk = 0, rst = 1;
  logic trap_req = 0, mret_req = 0, inst_req = 0, inst_wen = 0;
  logic [63:0] trap_cause = 0, trap_pc = 0, inst_wdata = 0;
  logic [1:0] inst_raddr = 0, inst_waddr = 0;
  logic sys_ack, busy, redirect_vld, inst_gnt, csrf_wen;
  logic [63:0] redirect_pc, inst_rdata, csrf_rdata, csrf_wdata;
  logic [1:0] csrf_raddr, csrf_waddr;
  logic [63:0] mem [4] = '{default: '0};
  typedef struct {
    logic req; logic wen; logic [1:0] waddr; logic [63:0] wdata;
    logic [1:0] raddr; logic gnt; logic [63:0] rdata;
  } vec_t;
  typedef struct { logic [1:0] a; logic [63:0] d; } wr_t;
  wr_t exp_q[$];
  vec_t tbl[7];
  int errors = 0, checks = 0;
  bit mon_en = 0;
`ifdef CSR_TRAP_VECTORED_EN
  localparam logic [63:0] EXP_VEC = 64'h8000_011c;
`else
  localparam logic [63:0] EXP_VEC = 64'h8000_0100;
`endif

  csr_trap_sequencer dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_req(mret_req), .sys_ack(sys_ack), .busy(busy), .redirect_vld(redirect_vld),
    .redirect_pc(redirect_pc), .inst_req(inst_req), .inst_gnt(inst_gnt), .inst_raddr(inst_raddr),
    .inst_rdata(inst_rdata), .inst_wen(inst_wen), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
    .csrf_raddr(csrf_raddr), .csrf_rdata(csrf_rdata), .csrf_waddr(csrf_waddr),
    .csrf_wdata(csrf_wdata), .csrf_wen(csrf_wen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (csrf_wen) mem[csrf_waddr] <= csrf_wdata;
  assign csrf_rdata = mem[csrf_raddr];

  task automatic chk(string name, logic [65:0] act, logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(logic [1:0] a, logic [63:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) if (mon_en && csrf_wen) begin
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_write: got addr %0d data %h, none expected", csrf_waddr, csrf_wdata);
    end else begin
      wr_t w;
      w = exp_q.pop_front();
      chk("csr_write", {csrf_waddr, csrf_wdata}, {w.a, w.d});
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_redirect(input bit hold_chk, output int n);
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      step;
      if (k == 1) begin
        trap_req = 0;
        mret_req = 0;
        #1;
      end
      if (redirect_vld) begin
        n = k;
        break;
      end
      if (hold_chk) chk("gnt_while_busy", 66'(inst_gnt), 66'(0));
    end
  endtask

  task automatic run_seq(string nm, bit t, bit m, int lat, logic [63:0] tgt, bit hold);
    int n;
    trap_req = t;
    mret_req = m;
    #1;
    chk({nm, "_ack"}, 66'(sys_ack), 66'(1));
    if (hold) chk({nm, "_gnt_blocked"}, 66'(inst_gnt), 66'(0));
    wait_redirect(hold, n);
    chk({nm, "_latency"}, 66'(n), 66'(lat));
    chk({nm, "_redirect_pc"}, 66'(redirect_pc), 66'(tgt));
  endtask

  initial begin
    tbl[0] = '{1, 1, 2'd3, 64'h8000_0100, 2'd1, 1, 64'ha00001800};
    tbl[1] = '{1, 1, 2'd1, 64'ha00001808, 2'd3, 1, 64'h8000_0100};
    tbl[2] = '{1, 1, 2'd2, 64'h1234, 2'd1, 1, 64'ha00001808};
    tbl[3] = '{0, 1, 2'd0, 64'hdead, 2'd2, 0, 64'h0};
    tbl[4] = '{1, 0, 2'd0, 64'h0, 2'd2, 1, 64'h1234};
    tbl[5] = '{1, 1, 2'd0, 64'h5, 2'd0, 1, 64'h0};
    tbl[6] = '{1, 0, 2'd0, 64'h0, 2'd0, 1, 64'h5};
    step;
    step;
    chk("rst_busy", 66'(busy), 66'(1));
    chk("rst_ack", 66'(sys_ack), 66'(0));
    chk("rst_rvld", 66'(redirect_vld), 66'(0));
    chk("rst_rpc", 66'(redirect_pc), 66'(0));
    rst = 0;
    mon_en = 1;
    push(2'd1, 64'ha00001800);
    #1;
    chk("init_wen", 66'(csrf_wen), 66'(1));
    chk("init_waddr", 66'(csrf_waddr), 66'(1));
    chk("init_wdata", 66'(csrf_wdata), 66'(64'ha00001800));
    chk("init_busy", 66'(busy), 66'(1));
    step;
    chk("idle_busy", 66'(busy), 66'(0));
    for (int i = 0; i < 7; i++) begin
      inst_req = tbl[i].req;
      inst_wen = tbl[i].wen;
      inst_waddr = tbl[i].waddr;
      inst_wdata = tbl[i].wdata;
      inst_raddr = tbl[i].raddr;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 66'(inst_gnt), 66'(tbl[i].gnt));
      chk($sformatf("tbl%0d_wen", i), 66'(csrf_wen), 66'(tbl[i].gnt & tbl[i].wen));
      if (tbl[i].gnt) chk($sformatf("tbl%0d_rdata", i), 66'(inst_rdata), 66'(tbl[i].rdata));
      if (tbl[i].gnt && tbl[i].wen) push(tbl[i].waddr, tbl[i].wdata);
      step;
    end
    inst_req = 0;
    inst_wen = 0;
    trap_pc = 64'h8000_0040;
    trap_cause = 64'hb;
    push(2'd2, 64'h8000_0040);
    push(2'd0, 64'hb);
    push(2'd1, 64'ha00001880);
    run_seq("trap", 1, 0, 5, 64'h8000_0100, 0);
    inst_req = 1;
    inst_wen = 1;
    inst_waddr = 2'd2;
    inst_wdata = 64'h8000_0044;
    push(2'd2, 64'h8000_0044);
    #1;
    chk("redirect_cycle_gnt", 66'(inst_gnt), 66'(1));
    step;
    inst_req = 0;
    inst_wen = 0;
    chk("rvld_pulse", 66'(redirect_vld), 66'(0));
    push(2'd1, 64'ha00001888);
    run_seq("mret", 0, 1, 3, 64'h8000_0044, 0);
    inst_req = 1;
    inst_wen = 1;
    inst_waddr = 2'd3;
    inst_wdata = 64'h8000_0200;
    trap_pc = 64'h8000_0080;
    push(2'd2, 64'h8000_0080);
    push(2'd0, 64'hb);
    push(2'd1, 64'ha00001880);
    run_seq("contend", 1, 0, 5, 64'h8000_0100, 1);
    chk("held_gnt", 66'(inst_gnt), 66'(1));
    push(2'd3, 64'h8000_0200);
    step;
    inst_req = 0;
    inst_wen = 0;
    trap_pc = 64'h8000_0090;
    push(2'd2, 64'h8000_0090);
    push(2'd0, 64'hb);
    push(2'd1, 64'ha00001800);
    run_seq("both", 1, 1, 5, 64'h8000_0200, 0);
    step;
    trap_pc = 64'h8000_00a0;
    push(2'd2, 64'h8000_00a0);
    trap_req = 1;
    #1;
    chk("abort_ack", 66'(sys_ack), 66'(1));
    step;
    trap_req = 0;
    step;
    rst = 1;
    #1;
    chk("abort_wen", 66'(csrf_wen), 66'(0));
    step;
    chk("abort_busy", 66'(busy), 66'(1));
    step;
    rst = 0;
    push(2'd1, 64'ha00001800);
    #1;
    chk("abort_init_wen", 66'(csrf_wen), 66'(1));
    for (int i = 0; i < 8; i++) begin
      step;
      chk("abort_no_redirect", 66'(redirect_vld), 66'(0));
    end
    inst_req = 1;
    inst_wen = 1;
    inst_waddr = 2'd3;
    inst_wdata = 64'h8000_0101;
    push(2'd3, 64'h8000_0101);
    #1;
    chk("vec_mtvec_gnt", 66'(inst_gnt), 66'(1));
    step;
    inst_req = 0;
    inst_wen = 0;
    trap_pc = 64'h8000_00b0;
    trap_cause = 64'h8000_0000_0000_0007;
    push(2'd2, 64'h8000_00b0);
    push(2'd0, 64'h8000_0000_0000_0007);
    push(2'd1, 64'ha00001800);
    run_seq("vec", 1, 0, 5, EXP_VEC, 0);
    step;
    step;
    chk("wr_queue_empty", 66'(exp_q.size()), 66'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
